// File: rtl/pll_mode_seq.sv
// pll_mode_seq: retunes a reconfigurable PLL between presets through its management port and qualifies the new lock
module pll_mode_seq #(
    parameter int NUM_MODES    = 2,
    parameter int NUM_WR       = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 2000000
) (
    input  logic                           refclk,
    input  logic                           rst,
    input  logic                           mode_req,
    input  logic [3:0]                     mode_sel,
    input  logic [NUM_MODES*NUM_WR*38-1:0] mode_tbl,
    output logic [5:0]                     mgmt_address,
    output logic                           mgmt_write,
    output logic [31:0]                    mgmt_writedata,
    output logic                           mgmt_read,
    input  logic                           mgmt_waitrequest,
    input  logic                           pll_locked,
    output logic                           busy,
    output logic                           done,
    output logic                           lock_err,
    output logic [3:0]                     cur_mode
);
    localparam int MW = NUM_MODES > 1 ? $clog2(NUM_MODES) : 1;
    localparam int WW = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, MODE_WR, TBL_WR, START_WR, WAIT_LOCK} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] target_q, target_d;
    logic [MW-1:0] pmode_q, pmode_d;
    logic          pend_q, pend_d;
    logic [WW-1:0] w_q, w_d;
    logic          wr_q, wr_d;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] to_q, to_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    cur_q, cur_d;
    logic          lk1_q, lk2_q;

    logic [37:0]   tbl [NUM_MODES][NUM_WR];
    logic [37:0]   ent;
    logic          req_ok, acc, skip, last;
    logic [MW-1:0] req_mode;

    for (genvar i = 0; i < NUM_MODES; i++) begin : g_m
        for (genvar j = 0; j < NUM_WR; j++) begin : g_w
            assign tbl[i][j] = mode_tbl[(i*NUM_WR+j)*38 +: 38];
        end
    end

    assign ent      = tbl[target_q][w_q];
    assign skip     = ent[37:32] == 6'h3F;
    assign last     = w_q == WW'(NUM_WR - 1);
    assign req_ok   = mode_req && (int'(mode_sel) < NUM_MODES);
    assign req_mode = mode_sel[MW-1:0];
    assign acc      = wr_q && !mgmt_waitrequest;

    assign mgmt_address   = addr_q;
    assign mgmt_write     = wr_q;
    assign mgmt_writedata = data_q;
    assign mgmt_read      = 1'b0;
    assign busy           = (state_q != IDLE) || pend_q;
    assign done           = done_q;
    assign lock_err       = err_q;
    assign cur_mode       = cur_q;

    // two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk1_q <= 1'b0;
            lk2_q <= 1'b0;
        end else begin
            lk1_q <= pll_locked;
            lk2_q <= lk1_q;
        end
    end

    // sequencer state and management-bus registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            pmode_q  <= '0;
            pend_q   <= 1'b0;
            w_q      <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            stab_q   <= '0;
            to_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            pmode_q  <= pmode_d;
            pend_q   <= pend_d;
            w_q      <= w_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            stab_q   <= stab_d;
            to_q     <= to_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cur_q    <= cur_d;
        end
    end

    // next state: each write state raises the strobe from an idle bus, holds it through stalls and drops it after acceptance
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        pmode_d  = pmode_q;
        pend_d   = pend_q;
        w_d      = w_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        stab_d   = stab_q;
        to_d     = to_q;
        done_d   = 1'b0;
        err_d    = err_q;
        cur_d    = cur_q;
        if (state_q != IDLE && req_ok) begin
            pend_d  = 1'b1;
            pmode_d = req_mode;
        end
        case (state_q)
            IDLE: begin
                if (req_ok || pend_q) begin
                    target_d = req_ok ? req_mode : pmode_q;
                    pend_d   = 1'b0;
                    state_d  = MODE_WR;
                end
            end
            MODE_WR: begin
                if (acc) begin
                    wr_d    = 1'b0;
                    w_d     = '0;
                    state_d = TBL_WR;
                end else if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = 6'h00;
                    data_d = 32'h0;
                end
            end
            TBL_WR: begin
                if (acc || (!wr_q && skip)) begin
                    wr_d    = 1'b0;
                    w_d     = last ? '0 : w_q + 1'b1;
                    state_d = last ? START_WR : TBL_WR;
                end else if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = ent[37:32];
                    data_d = ent[31:0];
                end
            end
            START_WR: begin
                if (acc) begin
                    wr_d    = 1'b0;
                    stab_d  = '0;
                    to_d    = '0;
                    state_d = WAIT_LOCK;
                end else if (!wr_q) begin
                    wr_d   = 1'b1;
                    addr_d = 6'h02;
                    data_d = 32'h1;
                end
            end
            WAIT_LOCK: begin
                stab_d = lk2_q ? (stab_q == SW'(LOCK_STABLE) ? stab_q : stab_q + 1'b1) : '0;
                to_d   = to_q == TW'(LOCK_TIMEOUT) ? to_q : to_q + 1'b1;
                if (stab_d == SW'(LOCK_STABLE)) begin
                    done_d  = 1'b1;
                    cur_d   = 4'(target_q);
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (to_d == TW'(LOCK_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pll_mode_seq.sv
// tb_pll_mode_seq: directed checks of the PLL mode sequencer
module tb_pll_mode_seq;
    localparam int NM = 2;
    localparam int NW = 4;
    localparam int LS = 1024;
    localparam int LT = 5000;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              mode_req = 1'b0;
    logic [3:0]        mode_sel = 4'd0;
    logic [NM*NW*38-1:0] mode_tbl;
    logic [5:0]        mgmt_address;
    logic              mgmt_write;
    logic [31:0]       mgmt_writedata;
    logic              mgmt_read;
    logic              mgmt_waitrequest = 1'b0;
    logic              pll_locked = 1'b0;
    logic              busy, done, lock_err;
    logic [3:0]        cur_mode;

    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    int k, sn, sb, c7, d0;
    logic [37:0] wq [$];
    logic [37:0] exp0 [4];
    logic [37:0] exp1 [5];

    always #5 refclk = ~refclk;

    pll_mode_seq #(.NUM_MODES(NM), .NUM_WR(NW), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)) dut (
        .refclk(refclk), .rst(rst), .mode_req(mode_req), .mode_sel(mode_sel), .mode_tbl(mode_tbl),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_read(mgmt_read), .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
        .busy(busy), .done(done), .lock_err(lock_err), .cur_mode(cur_mode)
    );

    // record every accepted write and every done cycle
    always @(posedge refclk) begin
        if (mgmt_write && !mgmt_waitrequest) wq.push_back({mgmt_address, mgmt_writedata});
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic req(input logic [3:0] s);
        mode_req = 1'b1;
        mode_sel = s;
        tick(1);
        mode_req = 1'b0;
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (wq.size() < n && t < 400) begin
            tick(1);
            t++;
        end
        chk("wr_count_reached", wq.size(), n);
    endtask

    task automatic wait_done(input int lim, output int t);
        t = 0;
        do begin
            tick(1);
            t++;
        end while (!done && t < lim);
    endtask

    task automatic chk_seq(input string tag, input int m);
        int n = m ? 5 : 4;
        chk({tag, "_count"}, wq.size(), n);
        for (int i = 0; i < n; i++)
            if (i < wq.size()) chk(tag, wq[i], m ? exp1[i] : exp0[i]);
    endtask

    initial begin
        exp0 = '{{6'h00, 32'h0}, {6'h04, 32'h606}, {6'h05, 32'h303}, {6'h02, 32'h1}};
        exp1 = '{{6'h00, 32'h0}, {6'h04, 32'h504}, {6'h07, 32'h29E2F3DB}, {6'h05, 32'h404}, {6'h02, 32'h1}};
        mode_tbl = {{6'h3F, 32'hDEADBEEF}, {6'h05, 32'h00000404}, {6'h07, 32'h29E2F3DB}, {6'h04, 32'h00000504},
                    {6'h05, 32'h00000303}, {6'h3F, 32'h0}, {6'h3F, 32'h0}, {6'h04, 32'h00000606}};
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", lock_err, 0);
        chk("rst_cur", cur_mode, 0);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_read", mgmt_read, 0);
        rst = 1'b0;
        tick(2);

        wq.delete();
        req(4'd1);
        chk("basic_busy", busy, 1);
        wait_wr(5);
        tick(50);
        pll_locked = 1'b1;
        wait_done(LS + 100, k);
        chk("basic_done_lat", k, LS + 2);
        chk("basic_busy_low", busy, 0);
        chk("basic_cur", cur_mode, 1);
        chk_seq("basic_wr", 1);
        tick(1);
        chk("basic_done_pulse", done, 0);
        chk("basic_ndone", n_done, 1);

        pll_locked = 1'b0;
        tick(5);
        wq.delete();
        req(4'd1);
        sn = 0;
        sb = 0;
        k = 0;
        while (wq.size() < 5 && k < 300) begin
            if (mgmt_write && mgmt_address == 6'h07 && sn < 7) begin
                mgmt_waitrequest = 1'b1;
                sn++;
                if (mgmt_writedata != 32'h29E2F3DB) sb++;
            end else mgmt_waitrequest = 1'b0;
            tick(1);
            k++;
        end
        mgmt_waitrequest = 1'b0;
        c7 = 0;
        foreach (wq[i]) if (wq[i][37:32] == 6'h07) c7++;
        chk("stall_cycles", sn, 7);
        chk("stall_data_stable", sb, 0);
        chk("stall_one_accept", c7, 1);
        chk_seq("stall_wr", 1);
        pll_locked = 1'b1;
        wait_done(LS + 100, k);
        chk("stall_done", done, 1);

        pll_locked = 1'b0;
        tick(5);
        wq.delete();
        req(4'd0);
        wait_wr(4);
        chk_seq("m0_wr", 0);
        d0 = n_done;
        pll_locked = 1'b1;
        tick(500);
        pll_locked = 1'b0;
        tick(10);
        chk("glitch_no_done", n_done, d0);
        pll_locked = 1'b1;
        wait_done(LS + 100, k);
        chk("glitch_lat", k, LS + 2);
        chk("glitch_cur", cur_mode, 0);

        pll_locked = 1'b0;
        tick(5);
        wq.delete();
        d0 = n_done;
        req(4'd1);
        wait_wr(5);
        k = 0;
        while (!lock_err && k < LT + 100) begin
            tick(1);
            k++;
        end
        chk("to_lat", k, LT);
        chk("to_cur", cur_mode, 0);
        chk("to_no_done", n_done, d0);
        chk("to_busy", busy, 0);

        wq.delete();
        req(4'd1);
        wait_wr(5);
        pll_locked = 1'b1;
        wait_done(LS + 100, k);
        chk("recover_err", lock_err, 0);
        chk("recover_cur", cur_mode, 1);

        pll_locked = 1'b0;
        tick(5);
        wq.delete();
        req(4'd1);
        req(4'd0);
        req(4'd1);
        wait_wr(5);
        chk_seq("q_first", 1);
        pll_locked = 1'b1;
        wait_done(LS + 100, k);
        chk("q_busy_at_done", busy, 1);
        wq.delete();
        tick(1);
        chk("q_busy_after", busy, 1);
        wait_wr(5);
        chk_seq("q_second", 1);
        wait_done(LS + 100, k);
        chk("q_lat", k, LS);
        wq.delete();
        tick(30);
        chk("q_idle", busy, 0);
        chk("q_no_third", wq.size(), 0);
        chk("q_cur", cur_mode, 1);

        pll_locked = 1'b0;
        tick(5);
        wq.delete();
        req(4'd1);
        req(4'd0);
        k = 0;
        while (!(mgmt_write && mgmt_address == 6'h07) && k < 200) begin
            tick(1);
            k++;
        end
        chk("rst_mid_reach", mgmt_address, 7);
        rst = 1'b1;
        tick(1);
        chk("rst_mid_write", mgmt_write, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cur", cur_mode, 0);
        chk("rst_mid_addr", mgmt_address, 0);
        chk("rst_mid_data", mgmt_writedata, 0);
        rst = 1'b0;
        wq.delete();
        tick(30);
        chk("rst_no_resume", wq.size(), 0);
        chk("rst_idle", busy, 0);

        req(4'd5);
        chk("inv_busy", busy, 0);
        tick(20);
        chk("inv_no_bus", wq.size(), 0);
        chk("inv_busy_late", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
